fir_decim_fifo: RTL and testbench
=================================

Name: fir_decim_fifo

Overview:
Downstream stage of the first-order FIR filter (filterfir). It consumes the filter's 10-bit unsigned output samples and decimates them by DECIM using block averaging (boxcar sum, then right shift). Results are buffered in a small FIFO and presented on a valid/ready stream to the Red Pitaya output/readout logic. Overflow is reported through a sticky flag.

Parameters:
DW, 10, sample width in bits; matches the FIR dataout width.
DECIM, 4, decimation factor; power of two, legal range 2..64.
DEPTH, 4, FIFO depth in words; power of two, minimum 2.
LOG2_DECIM, derived as log2(DECIM), not user-set.
AW, derived as log2(DEPTH), not user-set.

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  reset; asynchronous, active-low.
en  in  1  synchronous enable. When low, the accumulator and sample counter are held at 0.
din  in  DW  unsigned sample from the FIR stage.
din_valid  in  1  din is sampled on every rising edge where din_valid=1 and en=1.
dout  out  DW  FIFO head (averaged result). Driven to 0 whenever dout_valid=0.
dout_valid  out  1  FIFO is non-empty.
dout_ready  in  1  consumer accept. A pop occurs on an edge where dout_valid=1 and dout_ready=1.
fifo_level  out  AW+1  number of words currently in the FIFO, 0..DEPTH.
overflow  out  1  sticky flag: a result was dropped because the FIFO was full.
clr_ovf  in  1  synchronous clear for overflow.

Behaviour:
- Reset (rst=0, asynchronous assertion):
  - Accumulator, sample counter, FIFO pointers, fifo_level and overflow all go to 0.
  - dout_valid=0 and dout=0 immediately, without waiting for a clock edge.
  - Reset release is synchronous to clk.
- Accumulator width: DW+LOG2_DECIM bits, so it cannot wrap (e.g. 12 bits with the defaults).
- Sample counter cnt counts 0..DECIM-1.
- State machine:
  - IDLE: entered when en=0. Holds acc=0 and cnt=0. Transitions to ACCUM on the first edge with en=1.
  - ACCUM: on each accepted sample, if cnt<DECIM-1 then acc+=din and cnt+=1.
  - Block complete: if cnt==DECIM-1, result=(acc+din)>>LOG2_DECIM (truncating). The result is pushed into the FIFO on the same edge, and acc and cnt return to 0.
  - Cycles with din_valid=0 do not change acc or cnt (gaps are allowed).
- en deasserted mid-block: the partial sum is discarded and acc and cnt clear on the next edge. FIFO contents are retained and remain drainable while en=0.
- Latency: a result is written on the edge that accepts the DECIM-th sample. dout_valid=1 and dout=result are visible in the following cycle (1 clk).
- FIFO ordering and hold:
  - Strict first-in, first-out.
  - While dout_valid=1 and dout_ready=0, dout holds stable.
  - Pointers wrap modulo DEPTH.
- fifo_level update:
  - push only: +1.
  - pop only: -1.
  - push and pop on the same edge: unchanged.
- Full FIFO:
  - Push while full with no pop on the same edge: the result is dropped, FIFO contents are unchanged, and overflow=1.
  - Push and pop on the same edge while full: both take effect, fifo_level stays DEPTH, and overflow is not set.
- Empty FIFO with push on the same edge: no pop can occur (dout_valid=0). The word appears in the next cycle.
- overflow: remains set until clr_ovf=1 at an edge. If a drop and clr_ovf occur on the same edge, set wins and overflow stays 1.
- Arithmetic: all values are unsigned; no rounding and no saturation is needed.

Test Plan:
1. Async reset: drive rst=0 mid-block while the FIFO holds 2 words.
   - Required: dout_valid=0, dout=0, fifo_level=0 and overflow=0 before the next clk edge.
   - After release, the next 4 samples start a fresh block.
2. Basic decimation: DECIM=4, dout_ready=1, din=5,10,12,15 with one din_valid=0 gap between 10 and 12.
   - Required: exactly one output, dout=10 (42>>2).
   - dout_valid is high for 1 cycle, starting 1 clk after the sample 15 edge.
3. Full scale and ordering:
   - din=1023 ×4 -> dout=1023.
   - Then din=0,0,0,3 -> dout=0 (3>>2 truncates).
4. Overflow: dout_ready=0, 20 samples of value 8.
   - Required: fifo_level=4 after the 16th sample, and overflow=1 after the 20th.
   - Then dout_ready=1 drains four results of 8, with dout_valid falling after the 4th.
   - Then clr_ovf=1 -> overflow=0.
5. Full with simultaneous push and pop: FIFO full, dout_ready=1 on the edge of a block completion.
   - Required: fifo_level stays 4, overflow stays 0, and the output order is preserved.
6. Enable abort: din=100,100, then en=0 for 3 cycles, then en=1 with din=8,8,8,8.
   - Required: a single output of dout=8; the partial sum of 200 is never emitted.

Source files
------------

// File: rtl/fir_decim_fifo.sv
// Block-average decimator (sum of DECIM samples >> log2(DECIM)) feeding a small output FIFO.
// Latency: result visible on dout one clk after the edge that accepts the DECIM-th sample.
// Backpressure: dout_ready stalls the FIFO head; a result arriving while full is dropped and flagged sticky.

// Generic synchronous FIFO: in_rdy also admits a push into a full FIFO when a pop happens on the same edge.
// Latency: a pushed word is visible on out_dat in the following cycle.
// Backpressure: out_rdy low holds the head stable; in_rdy low while full with no pop.
module sync_fifo #(
  parameter int W     = 10,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_vld,
  output logic          in_rdy,
  input  logic [W-1:0]  in_dat,
  output logic          out_vld,
  input  logic          out_rdy,
  output logic [W-1:0]  out_dat,
  output logic [AW:0]   level
);

  localparam logic [AW:0]   LEVEL_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   LEVEL_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE    = AW'(1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   level_q, level_d;
  logic          full;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (level_q == LEVEL_FULL);
  assign out_vld = (level_q != '0);
  // Head is forced to zero when empty so stale storage never leaks out.
  assign out_dat = out_vld ? mem_q[rd_ptr_q] : '0;
  assign level   = level_q;
  // A full FIFO can still take a word when the head leaves on the same edge.
  assign in_rdy  = !full || (out_vld && out_rdy);
  assign push_ok = in_vld && in_rdy;
  assign pop_ok  = out_vld && out_rdy;

  // Next-state for storage, pointers (wrapping modulo DEPTH) and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = in_dat;
      wr_ptr_d        = wr_ptr_q + PTR_ONE;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push_ok, pop_ok})
      2'b10:   level_d = level_q + LEVEL_ONE;
      2'b01:   level_d = level_q - LEVEL_ONE;
      default: level_d = level_q;
    endcase
  end

  // FIFO state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

endmodule

// Decimator top: accumulate DECIM accepted samples, push the truncated average into sync_fifo.
// Latency: 1 clk from the completing sample edge to dout_valid.
// Backpressure: none toward din; results are dropped when the FIFO is full and not popping.
module fir_decim_fifo #(
  parameter int DW           = 10,
  parameter int DECIM        = 4,
  parameter int DEPTH        = 4,
  localparam int LOG2_DECIM  = $clog2(DECIM),
  localparam int AW          = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  input  logic          dout_ready,
  output logic [AW:0]   fifo_level,
  output logic          overflow,
  input  logic          clr_ovf
);

  // DECIM is a power of two in 2..64 and DEPTH a power of two >= 2; the
  // truncating shift and the free-running pointer wrap both depend on that.

  // Wide enough to hold DECIM full-scale samples without wrapping.
  localparam int ACC_W = DW + LOG2_DECIM;
  localparam logic [LOG2_DECIM-1:0] CNT_MAX = LOG2_DECIM'(DECIM - 1);
  localparam logic [LOG2_DECIM-1:0] CNT_ONE = LOG2_DECIM'(1);

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [ACC_W-1:0]      acc_q, acc_d;
  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;

  logic [ACC_W-1:0]      sum;
  logic [DW-1:0]         result;
  logic                  blk_done;
  logic                  take;
  logic                  fifo_in_rdy;
  logic                  drop;

  assign sum    = acc_q + ACC_W'(din);
  assign result = DW'(sum >> LOG2_DECIM);
  assign take   = en && din_valid;

  // FSM and accumulator: en low clears everything (partial block discarded),
  // the DECIM-th accepted sample completes the block and emits a push.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    blk_done = 1'b0;
    case (state_q)
      IDLE: begin
        acc_d = '0;
        cnt_d = '0;
        if (en) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (!en) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        acc_d   = '0;
        cnt_d   = '0;
      end
    endcase
    // Samples count from the very first enabled edge, including the one
    // that moves IDLE to ACCUM (acc_q and cnt_q are already zero there).
    if (take) begin
      if (cnt_q == CNT_MAX) begin
        blk_done = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + CNT_ONE;
      end
    end
  end

  // A completed block that the FIFO cannot take is lost; the flag is sticky
  // and a drop on the same edge as a clear keeps it set.
  assign drop = blk_done && !fifo_in_rdy;

  // Sticky overflow next-state.
  always_comb begin
    ovf_d = ovf_q;
    if (clr_ovf) begin
      ovf_d = 1'b0;
    end
    if (drop) begin
      ovf_d = 1'b1;
    end
  end

  // Decimator state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign overflow = ovf_q;

  sync_fifo #(
    .W     (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .in_vld  (blk_done),
    .in_rdy  (fifo_in_rdy),
    .in_dat  (result),
    .out_vld (dout_valid),
    .out_rdy (dout_ready),
    .out_dat (dout),
    .level   (fifo_level)
  );

endmodule

// File: tb/tb_fir_decim_fifo.sv
// Directed bench for fir_decim_fifo: expected averages queued at stimulus time,
// a negedge monitor compares every accepted output word against the queue head.
module tb_fir_decim_fifo;

  localparam int DW    = 10;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic [DW-1:0] din;
  logic          din_valid;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          dout_ready;
  logic [AW:0]   fifo_level;
  logic          overflow;
  logic          clr_ovf;

  int n_checks = 0;
  int n_pass   = 0;
  int exp_q[$];

  fir_decim_fifo #(.DW(DW), .DECIM(4), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .fifo_level (fifo_level),
    .overflow   (overflow),
    .clr_ovf    (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  // Monitor: a word is consumed at the next posedge whenever valid&ready here.
  always @(negedge clk) begin
    int e;
    if (rst && dout_valid && dout_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_output: got %0d, expected no output", dout);
      end else begin
        e = exp_q.pop_front();
        if (int'(dout) == e) n_pass++;
        else $display("FAIL output_value: got %0d, expected %0d", dout, e);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic samp(input int v);
    din       = DW'(v);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
  endtask

  task automatic block(input int v);
    exp_q.push_back(v);
    repeat (4) samp(v);
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; din = '0; din_valid = 1'b0;
    dout_ready = 1'b1; clr_ovf = 1'b0;
    #1;
    check("reset_dout_valid", int'(dout_valid), 0);
    check("reset_dout", int'(dout), 0);
    check("reset_level", int'(fifo_level), 0);
    check("reset_overflow", int'(overflow), 0);
    repeat (2) step();
    rst = 1'b1;
    en  = 1'b1;
    step();

    // Basic decimation with a gap: (5+10+12+15)>>2 = 10.
    samp(5);
    samp(10);
    step();
    samp(12);
    check("t2_no_early_valid", int'(dout_valid), 0);
    exp_q.push_back(10);
    samp(15);
    check("t2_valid_after_block", int'(dout_valid), 1);
    check("t2_dout", int'(dout), 10);
    step();
    check("t2_valid_one_cycle", int'(dout_valid), 0);

    // Full scale, then truncation: 4092>>2 = 1023, 3>>2 = 0.
    block(1023);
    step();
    samp(0); samp(0); samp(0);
    exp_q.push_back(0);
    samp(3);
    repeat (3) step();
    check("t3_drained", exp_q.size(), 0);

    // Overflow: five blocks of 8 with no consumer; fifth is dropped.
    dout_ready = 1'b0;
    for (int b = 0; b < 5; b++) begin
      repeat (4) samp(8);
      if (b < 4) exp_q.push_back(8);
      if (b == 3) begin
        check("t4_level_full", int'(fifo_level), 4);
        check("t4_no_ovf_yet", int'(overflow), 0);
      end
    end
    check("t4_overflow_set", int'(overflow), 1);
    check("t4_level_after_drop", int'(fifo_level), 4);
    dout_ready = 1'b1;
    repeat (3) step();
    check("t4_valid_before_last", int'(dout_valid), 1);
    step();
    check("t4_valid_after_last", int'(dout_valid), 0);
    check("t4_level_empty", int'(fifo_level), 0);
    check("t4_overflow_sticky", int'(overflow), 1);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    check("t4_overflow_cleared", int'(overflow), 0);

    // Full FIFO with push and pop on the same edge.
    dout_ready = 1'b0;
    block(4); block(8); block(12); block(16);
    check("t5_level_full", int'(fifo_level), 4);
    samp(20); samp(20); samp(20);
    check("t5_head_held", int'(dout), 4);
    exp_q.push_back(20);
    dout_ready = 1'b1;
    samp(20);
    check("t5_level_stays_full", int'(fifo_level), 4);
    check("t5_no_overflow", int'(overflow), 0);
    repeat (5) step();
    check("t5_level_drained", int'(fifo_level), 0);
    check("t5_dout_zero_when_empty", int'(dout), 0);

    // Enable abort: the 100+100 partial block must vanish.
    samp(100); samp(100);
    en = 1'b0;
    repeat (3) step();
    en = 1'b1;
    block(8);
    repeat (3) step();
    check("t6_single_output", exp_q.size(), 0);

    // Asynchronous reset mid-block with two words held.
    dout_ready = 1'b0;
    block(40); block(44);
    samp(7); samp(9);
    check("t1_level_before", int'(fifo_level), 2);
    #2;
    rst = 1'b0;
    #1;
    check("t1_async_dout_valid", int'(dout_valid), 0);
    check("t1_async_dout", int'(dout), 0);
    check("t1_async_level", int'(fifo_level), 0);
    check("t1_async_overflow", int'(overflow), 0);
    exp_q.delete();
    step();
    rst = 1'b1;
    dout_ready = 1'b1;
    step();
    check("t1_level_after_release", int'(fifo_level), 0);
    // (1+2+3+6)>>2 = 3; a surviving partial sum would complete early and differ.
    samp(1); samp(2); samp(3);
    check("t1_no_early_block", int'(dout_valid), 0);
    exp_q.push_back(3);
    samp(6);
    repeat (4) step();
    check("t1_fresh_block_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
